// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced button level into single-cycle press/release/short/long
// strobes, an optional auto-repeat strobe while held, and a registered "held" level.
// Optional feature macro: BTN_EVENT_AUTOREPEAT_EN (defined: auto-repeat strobes are generated;
// undefined: repeat counter is not built and repeat_pulse is tied low).
// All outputs are registered; every strobe appears on the edge that samples its trigger.

module button_event_decoder #(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned CNT_WIDTH     = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic debounce,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  // Elaboration-time sanity checks on the configuration.
  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("button_event_decoder: LONG_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("button_event_decoder: REPEAT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StLong
  } state_e;

  // Hold count value on the edge that promotes a press to long.
  localparam logic [CNT_WIDTH-1:0] HoldLast = CNT_WIDTH'(LONG_CYCLES - 1);

  state_e               state_q;
  logic                 btn_q;
  logic [CNT_WIDTH-1:0] hold_cnt_q;

`ifdef BTN_EVENT_AUTOREPEAT_EN
  // Repeat count value on the edge that emits a repeat strobe.
  localparam logic [CNT_WIDTH-1:0] RepLast = CNT_WIDTH'(REPEAT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] rep_cnt_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  // Event FSM: state, counters and all registered outputs in one clocked process.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      btn_q         <= 1'b0;
      hold_cnt_q    <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      held          <= 1'b0;
`ifdef BTN_EVENT_AUTOREPEAT_EN
      rep_cnt_q     <= '0;
      repeat_pulse  <= 1'b0;
`endif
    end else begin
      btn_q         <= debounce;
      // Strobes default low so each lasts exactly one cycle.
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
`ifdef BTN_EVENT_AUTOREPEAT_EN
      repeat_pulse  <= 1'b0;
`endif

      case (state_q)
        StIdle: begin
          if (debounce && !btn_q) begin
            press_pulse <= 1'b1;
            held        <= 1'b1;
            hold_cnt_q  <= CNT_WIDTH'(1);
            state_q     <= StPressed;
          end
        end

        StPressed: begin
          if (debounce) begin
            if (hold_cnt_q == HoldLast) begin
              long_press <= 1'b1;
`ifdef BTN_EVENT_AUTOREPEAT_EN
              rep_cnt_q  <= '0;
`endif
              state_q    <= StLong;
            end else begin
              hold_cnt_q <= hold_cnt_q + CNT_WIDTH'(1);
            end
          end else begin
            release_pulse <= 1'b1;
            short_press   <= 1'b1;
            held          <= 1'b0;
            hold_cnt_q    <= '0;
            state_q       <= StIdle;
          end
        end

        StLong: begin
          if (debounce) begin
            // hold_cnt_q is frozen here so arbitrarily long holds never wrap it.
`ifdef BTN_EVENT_AUTOREPEAT_EN
            if (rep_cnt_q == RepLast) begin
              repeat_pulse <= 1'b1;
              rep_cnt_q    <= '0;
            end else begin
              rep_cnt_q    <= rep_cnt_q + CNT_WIDTH'(1);
            end
`endif
          end else begin
            release_pulse <= 1'b1;
            held          <= 1'b0;
            hold_cnt_q    <= '0;
            state_q       <= StIdle;
          end
        end

        default: begin
          held       <= 1'b0;
          hold_cnt_q <= '0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

endmodule
